// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver (start, 8 data bits LSB first, optional parity, stop).
//
// Parameters:
//   PRESCALE    clk cycles per bit; must be even and >= 8.
// Ports:
//   clk         receive clock, PRESCALE x bit rate
//   rst         asynchronous active-high reset
//   RX_IN       serial line, idle high, asynchronous to clk
//   Par_en      1 = frame carries a parity bit (latched at start detection)
//   Par_type    0 = even, 1 = odd parity (latched at start detection)
//   P_Data      last correctly received byte
//   Data_valid  one-cycle strobe, P_Data updated this cycle
//   Par_error   one-cycle strobe, parity mismatch in the frame just ended
//   Stop_error  one-cycle strobe, stop bit sampled low
//
// Optional feature macro: UART_RX_MAJORITY_EN
//   Defined:   bit value is the majority of samples at edges PRESCALE/2-1, PRESCALE/2, PRESCALE/2+1.
//   Undefined: bit value is the single sample at edge PRESCALE/2.
//   The decision is registered at the end of edge PRESCALE/2+1 in both builds.

module uart_rx #(
    parameter int unsigned PRESCALE = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX_IN,
    input  logic       Par_en,
    input  logic       Par_type,
    output logic [7:0] P_Data,
    output logic       Data_valid,
    output logic       Par_error,
    output logic       Stop_error
);

    localparam int unsigned EW = $clog2(PRESCALE);
    localparam logic [EW-1:0] EdgeMid  = EW'(PRESCALE / 2);
    localparam logic [EW-1:0] EdgeDec  = EW'(PRESCALE / 2 + 1);
    localparam logic [EW-1:0] EdgeLast = EW'(PRESCALE - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      sync_q;
    logic            rx_s;
    logic [EW-1:0]   edge_cnt_q, edge_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_en_q, par_en_d;
    logic            par_type_q, par_type_d;
    logic            par_mis_q, par_mis_d;
    logic            samp_q, samp_d;
    logic [7:0]      p_data_q, p_data_d;
    logic            data_valid_q, data_valid_d;
    logic            par_error_q, par_error_d;
    logic            stop_error_q, stop_error_d;
    logic            bit_val;
    logic            decide;
    logic            bit_end;

    assign rx_s    = sync_q[1];
    assign decide  = (edge_cnt_q == EdgeDec);
    assign bit_end = (edge_cnt_q == EdgeLast);

    // Mid-bit sample, captured at the end of edge PRESCALE/2.
    assign samp_d = (edge_cnt_q == EdgeMid) ? rx_s : samp_q;

`ifdef UART_RX_MAJORITY_EN
    logic samp_early_q, samp_early_d;

    assign samp_early_d = (edge_cnt_q == EdgeMid - EW'(1)) ? rx_s : samp_early_q;

    // Third vote is the live sample during the decision edge itself.
    assign bit_val = (samp_early_q & samp_q) | (samp_early_q & rx_s) | (samp_q & rx_s);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp_early_q <= 1'b1;
        end else begin
            samp_early_q <= samp_early_d;
        end
    end
`else
    assign bit_val = samp_q;
`endif

    always_comb begin
        state_d      = state_q;
        edge_cnt_d   = bit_end ? '0 : edge_cnt_q + EW'(1);
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_en_d     = par_en_q;
        par_type_d   = par_type_q;
        par_mis_d    = par_mis_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_error_d  = 1'b0;
        stop_error_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                edge_cnt_d = '0;
                if (!rx_s) begin
                    // Detecting cycle is edge 0 of the start bit.
                    state_d    = StStart;
                    edge_cnt_d = EW'(1);
                    bit_cnt_d  = '0;
                    par_en_d   = Par_en;
                    par_type_d = Par_type;
                    par_mis_d  = 1'b0;
                end
            end
            StStart: begin
                if (decide && bit_val) begin
                    // Start bit not low at mid-bit: glitch, abandon silently.
                    state_d    = StIdle;
                    edge_cnt_d = '0;
                end else if (bit_end) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (decide) begin
                    shift_d = {bit_val, shift_q[7:1]};
                end
                if (bit_end) begin
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? StParity : StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            StParity: begin
                if (decide) begin
                    par_mis_d = bit_val ^ (^shift_q) ^ par_type_q;
                end
                if (bit_end) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (decide) begin
                    // Leave straight away so a back-to-back start edge is not missed.
                    state_d      = StIdle;
                    edge_cnt_d   = '0;
                    stop_error_d = !bit_val;
                    par_error_d  = par_mis_q;
                    if (bit_val && !par_mis_q) begin
                        p_data_d     = shift_q;
                        data_valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d    = StIdle;
                edge_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q       <= 2'b11;
            state_q      <= StIdle;
            edge_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_en_q     <= 1'b0;
            par_type_q   <= 1'b0;
            par_mis_q    <= 1'b0;
            samp_q       <= 1'b1;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_error_q  <= 1'b0;
            stop_error_q <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], RX_IN};
            state_q      <= state_d;
            edge_cnt_q   <= edge_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_en_q     <= par_en_d;
            par_type_q   <= par_type_d;
            par_mis_q    <= par_mis_d;
            samp_q       <= samp_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_error_q  <= par_error_d;
            stop_error_q <= stop_error_d;
        end
    end

    assign P_Data     = p_data_q;
    assign Data_valid = data_valid_q;
    assign Par_error  = par_error_q;
    assign Stop_error = stop_error_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at PRESCALE=8: good frames, parity/stop errors, glitches,
// back-to-back frames and mid-frame reset. Strobes are logged with their cycle numbers.

module tb_uart_rx;

    localparam int unsigned P = 8;

    logic       clk;
    logic       rst;
    logic       RX_IN;
    logic       Par_en;
    logic       Par_type;
    logic [7:0] P_Data;
    logic       Data_valid;
    logic       Par_error;
    logic       Stop_error;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    int       dv_cyc[$];
    logic [7:0] dv_dat[$];
    int       pe_cyc[$];
    int       se_cyc[$];

    int b_dv, b_pe, b_se;
    int t0, t1;
    logic [7:0] exp_g;

    uart_rx #(
        .PRESCALE(P)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .RX_IN     (RX_IN),
        .Par_en    (Par_en),
        .Par_type  (Par_type),
        .P_Data    (P_Data),
        .Data_valid(Data_valid),
        .Par_error (Par_error),
        .Stop_error(Stop_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cyc numbers posedges; at a negedge it equals the index of the preceding posedge.
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (Data_valid) begin
            dv_cyc.push_back(cyc);
            dv_dat.push_back(P_Data);
        end
        if (Par_error)  pe_cyc.push_back(cyc);
        if (Stop_error) se_cyc.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic snap();
        b_dv = dv_cyc.size();
        b_pe = pe_cyc.size();
        b_se = se_cyc.size();
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame, one value per clk; gbit selects a bit to get a 1-cycle low at mid-bit.
    // t0_o is the posedge that samples the first low level. Stops early after maxcyc cycles.
    task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                              input logic stopv, input int gbit, input int maxcyc,
                              output int t0_o);
        logic [10:0] frm;
        int nbits;
        int n;
        frm    = '1;
        frm[0] = 1'b0;
        for (int i = 0; i < 8; i++) frm[1+i] = d[i];
        if (pen) begin
            frm[9]  = pbit;
            frm[10] = stopv;
            nbits   = 11;
        end else begin
            frm[9] = stopv;
            nbits  = 10;
        end
        t0_o = cyc + 1;
        n    = 0;
        for (int b = 0; b < nbits; b++) begin
            for (int k = 0; k < int'(P); k++) begin
                if (n == maxcyc) return;
                RX_IN = (b == gbit && k == int'(P / 2)) ? 1'b0 : frm[b];
                @(negedge clk);
                n++;
            end
        end
        RX_IN = 1'b1;
    endtask

    initial begin
        rst      = 1'b1;
        RX_IN    = 1'b1;
        Par_en   = 1'b0;
        Par_type = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_pdata", 32'(P_Data), 32'h0);
        chk("reset_strobes", 32'({Data_valid, Par_error, Stop_error}), 32'h0);
        rst = 1'b0;
        idle(5);

        // 0xA5, no parity: Data_valid at T0+79
        snap();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, -1, 1000, t0);
        idle(6);
        chk("a5_dv_count", 32'(dv_cyc.size() - b_dv), 32'd1);
        chk("a5_dv_cycle", 32'(dv_cyc[b_dv]), 32'(t0 + 79));
        chk("a5_data", 32'(dv_dat[b_dv]), 32'hA5);
        chk("a5_err_count", 32'((pe_cyc.size() - b_pe) + (se_cyc.size() - b_se)), 32'd0);

        // 0x0F, even parity, correct parity bit 0: Data_valid at T0+87
        Par_en   = 1'b1;
        Par_type = 1'b0;
        snap();
        send_frame(8'h0F, 1'b1, 1'b0, 1'b1, -1, 1000, t0);
        idle(6);
        chk("par_ok_dv_cycle", 32'(dv_cyc[b_dv]), 32'(t0 + 87));
        chk("par_ok_data", 32'(P_Data), 32'h0F);
        chk("par_ok_err_count", 32'((pe_cyc.size() - b_pe) + (se_cyc.size() - b_se)), 32'd0);

        // Same byte, wrong parity bit: Par_error only, P_Data held
        snap();
        send_frame(8'h0F, 1'b1, 1'b1, 1'b1, -1, 1000, t0);
        idle(6);
        chk("par_bad_pe_count", 32'(pe_cyc.size() - b_pe), 32'd1);
        chk("par_bad_pe_cycle", 32'(pe_cyc[b_pe]), 32'(t0 + 87));
        chk("par_bad_dv_se", 32'((dv_cyc.size() - b_dv) + (se_cyc.size() - b_se)), 32'd0);
        chk("par_bad_hold", 32'(P_Data), 32'h0F);

        // 0x3C with stop low, no parity: Stop_error only
        Par_en = 1'b0;
        snap();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, -1, 1000, t0);
        idle(12);
        chk("stop_se_count", 32'(se_cyc.size() - b_se), 32'd1);
        chk("stop_se_cycle", 32'(se_cyc[b_se]), 32'(t0 + 79));
        chk("stop_dv_pe", 32'((dv_cyc.size() - b_dv) + (pe_cyc.size() - b_pe)), 32'd0);
        chk("stop_hold", 32'(P_Data), 32'h0F);

        // 2-cycle low glitch: no strobes
        snap();
        RX_IN = 1'b0;
        repeat (2) @(negedge clk);
        idle(100);
        chk("glitch_strobes",
            32'((dv_cyc.size() - b_dv) + (pe_cyc.size() - b_pe) + (se_cyc.size() - b_se)),
            32'd0);

        // 0xFF with a 1-cycle low at mid-bit of data bit 3
`ifdef UART_RX_MAJORITY_EN
        exp_g = 8'hFF;
`else
        exp_g = 8'hF7;
`endif
        snap();
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 4, 1000, t0);
        idle(6);
        chk("midglitch_dv_count", 32'(dv_cyc.size() - b_dv), 32'd1);
        chk("midglitch_data", 32'(dv_dat[b_dv]), 32'(exp_g));

        // Three back-to-back frames
        snap();
        send_frame(8'h00, 1'b0, 1'b0, 1'b1, -1, 1000, t0);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1, -1, 1000, t1);
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, -1, 1000, t1);
        idle(6);
        chk("b2b_dv_count", 32'(dv_cyc.size() - b_dv), 32'd3);
        chk("b2b_data0", 32'(dv_dat[b_dv]), 32'h00);
        chk("b2b_data1", 32'(dv_dat[b_dv+1]), 32'hFF);
        chk("b2b_data2", 32'(dv_dat[b_dv+2]), 32'h55);
        chk("b2b_cycle0", 32'(dv_cyc[b_dv]), 32'(t0 + 79));
        chk("b2b_cycle2", 32'(dv_cyc[b_dv+2]), 32'(t0 + 239));

        // Reset mid-frame: outputs clear asynchronously
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1, -1, 40, t0);
        rst   = 1'b1;
        RX_IN = 1'b1;
        #1;
        chk("midrst_pdata", 32'(P_Data), 32'h0);
        chk("midrst_strobes", 32'({Data_valid, Par_error, Stop_error}), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        idle(4);

        snap();
        send_frame(8'h96, 1'b0, 1'b0, 1'b1, -1, 1000, t0);
        idle(6);
        chk("post_rst_dv_count", 32'(dv_cyc.size() - b_dv), 32'd1);
        chk("post_rst_dv_cycle", 32'(dv_cyc[b_dv]), 32'(t0 + 79));
        chk("post_rst_data", 32'(P_Data), 32'h96);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Oversampling UART receiver: the downstream stage that consumes the serial stream produced by the transmitter. Recovers start/data/parity/stop framing from `RX_IN` using the same framing and parity settings as the transmitter. Delivers each good byte as `P_Data` with a one-cycle `Data_valid` strobe. Flags parity and framing errors.

## Interface
- `PRESCALE`, default 8: clk cycles per bit. Must be even and ≥ 8.
- `clk`  input  1  receive clock, `PRESCALE`× the bit rate.
- `rst`  input  1  asynchronous, active-high reset.
- `RX_IN`  input  1  serial line; idle high; asynchronous to `clk`.
- `Par_en`  input  1  1 = frame carries a parity bit.
- `Par_type`  input  1  0 = even, 1 = odd parity.
- `P_Data`  output  8  last correctly received byte, LSB received first.
- `Data_valid`  output  1  one-cycle strobe; `P_Data` is new this cycle.
- `Par_error`  output  1  one-cycle strobe; parity mismatch in the frame just ended.
- `Stop_error`  output  1  one-cycle strobe; stop bit sampled low.

## Operation
- `RX_IN` passes through a 2-flop synchronizer. Both flops reset to 1. `rx_s` is the synchronized value.
- Edge counter `edge_cnt` runs 0..PRESCALE-1 within each bit. Bit counter `bit_cnt` runs 0..7 in DATA.
- The sample point is edge `PRESCALE/2`. The bit value is decided at edge `PRESCALE/2+1` (see Configuration).
- FSM states:
  - IDLE: when `rx_s`==0, go to START. The detecting cycle counts as edge 0. Latch `Par_en` and `Par_type`; mid-frame changes to these inputs are ignored.
  - START: at decision, if the bit is 1 it is a glitch: return to IDLE with no strobes. At edge PRESCALE-1, go to DATA.
  - DATA: at decision, shift the bit into the shift register LSB-first. After bit 7 ends, go to PARITY if `Par_en`, else STOP.
  - PARITY: at decision, compare the bit with the XOR of the 8 data bits, inverted if odd parity. Store the mismatch result. At end of bit, go to STOP.
  - STOP: at decision, evaluate the frame and go directly to IDLE. No wait for the end of the stop bit, which allows resync on back-to-back frames.
- Frame evaluation, registered:
  - If stop = 1 and no parity mismatch: load `P_Data` and pulse `Data_valid`.
  - If stop = 0: pulse `Stop_error`.
  - If parity mismatch: pulse `Par_error`.
  - On any error, `Data_valid` stays 0 and `P_Data` holds its old value. `Stop_error` and `Par_error` may pulse together.
- Reset, including reset mid-frame: state IDLE, counters 0. `P_Data`=0x00; `Data_valid`, `Par_error` and `Stop_error` all 0. The synchronizer is set to 1.

## Timing
- T0 is the posedge at which the first low `RX_IN` is captured. `rx_s` goes low at T0+1.
- Edge k of bit b is the cycle starting at T0+1+b·PRESCALE+k. The start bit is b=0. Data bits are b=1..8. Parity, when enabled, is b=9. The stop bit is at N = 9 without parity, or 10 with parity.
- Strobes are high for exactly one cycle, starting at T0 + N·PRESCALE + PRESCALE/2 + 3.
  - PRESCALE=8: T0+79 without parity, T0+87 with parity.
- The earliest next start detection is the cycle after the stop decision. A back-to-back frame whose start edge falls at the nominal stop-bit end is received correctly.
- Decision timing is identical with and without the Configuration macro.

## Configuration
- `UART_RX_MAJORITY_EN`:
  - Defined: the bit value is the majority of `rx_s` samples at edges PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1. The decision is taken at the end of edge PRESCALE/2+1.
  - Undefined: the single sample at edge PRESCALE/2 is used. The decision is still registered at edge PRESCALE/2+1.
- The macro applies to every bit, including the start-glitch check.

## Test plan
- PRESCALE=8, `Par_en`=0, send 0xA5 -> `P_Data`=0xA5 and `Data_valid` high for one cycle at T0+79. No error strobes.
- `Par_en`=1, `Par_type`=0, send 0x0F with parity 0 -> `Data_valid` at T0+87, `P_Data`=0x0F. Repeat with a wrong parity bit (1) -> `Par_error` pulse only; `P_Data` still 0x0F.
- Send 0x3C with the stop bit forced low -> `Stop_error` pulse; `Data_valid` stays 0; `P_Data` unchanged.
- Drive a 2-cycle low glitch on `RX_IN` -> FSM returns to IDLE with no strobes. Then a 1-cycle low pulse at edge PRESCALE/2 of a data bit that is otherwise 1:
  - with `UART_RX_MAJORITY_EN`: byte received correctly;
  - without: that bit is received as 0.
- Three back-to-back frames 0x00, 0xFF, 0x55, each start bit immediately after the previous stop bit -> three `Data_valid` strobes with correct data. Then assert `rst` mid-frame -> all outputs 0 within the same cycle; the next full frame is received correctly.
